// File: rtl/obc_challenge_sequencer_pkg.sv
// Shared types and helpers for the OBC challenge/response sequencer.
// Holds the state encoding, the question LFSR step and the expected-answer rule.
package obc_challenge_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CHECK,
        ST_PAUSE,
        ST_SHUTDOWN
    } state_e;

    localparam logic [3:0] LFSR_SEED = 4'b0001;

    // Maximal-length 4-bit sequence; the all-zero word is unreachable from the seed.
    function automatic logic [3:0] lfsr_next(input logic [3:0] l);
        return {l[2:0], l[3] ^ l[2]};
    endfunction

    function automatic logic [3:0] expected_answer(input logic [3:0] q);
        return {q[3] ^ q[2], q[2] ^ q[1], q[1] ^ q[0], ~q[0]};
    endfunction

endpackage

// File: rtl/obc_challenge_sequencer_if.sv
// Challenge/answer handshake between the sequencer (master) and the OBC (slave).
// Question is held stable while question_valid is high; answer_valid is a one-cycle strobe.
interface obc_challenge_sequencer_if;
    logic [3:0] question;
    logic       question_valid;
    logic [3:0] answer_obc;
    logic       answer_valid;

    modport master (
        output question,
        output question_valid,
        input  answer_obc,
        input  answer_valid
    );

    modport slave (
        input  question,
        input  question_valid,
        output answer_obc,
        output answer_valid
    );
endinterface

// File: rtl/obc_question_lfsr.sv
// Question word generator: 4-bit LFSR stepping once per advance pulse.
// Latency: value reflects an advance on the next clock; backpressure: none.
module obc_question_lfsr
    import obc_challenge_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       advance,
    output logic [3:0] value
);

    logic [3:0] lfsr_q;
    logic [3:0] lfsr_d;

    always_comb begin
        lfsr_d = advance ? lfsr_next(lfsr_q) : lfsr_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value = lfsr_q;

endmodule

// File: rtl/obc_challenge_sequencer.sv
// Watchdog sequencer: challenges the OBC, grades answers, escalates to backup after repeated failures.
// Latency: question 1 cycle after ISSUE, verdict pulse 1 cycle after CHECK; backpressure: none, OBC must answer within TIMEOUT.
module obc_challenge_sequencer
    import obc_challenge_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT        = 16,
    parameter int unsigned ROUND_INTERVAL = 8,
    parameter int unsigned FAIL_LIMIT     = 3
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    obc_challenge_sequencer_if.master        obc,
    output logic                             pass,
    output logic                             obc_reset,
    output logic                             override,
    output logic [3:0]                       fail_count
);

    localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);
    localparam logic [7:0] PAUSE_LAST = 8'(ROUND_INTERVAL - 1);
    localparam logic [3:0] FAIL_MAX   = 4'(FAIL_LIMIT);

    state_e     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic [3:0] question_q, question_d;
    logic       question_valid_q, question_valid_d;
    logic [3:0] answer_q, answer_d;
    logic       timed_out_q, timed_out_d;
    logic       pass_q, pass_d;
    logic       obc_reset_q, obc_reset_d;
    logic       override_q, override_d;
    logic [3:0] fail_count_q, fail_count_d;
    logic [3:0] fail_next;
    logic       lfsr_adv;
    logic [3:0] lfsr_val;

    obc_question_lfsr u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .advance (lfsr_adv),
        .value   (lfsr_val)
    );

    always_comb begin
        state_d          = state_q;
        timer_d          = timer_q;
        question_d       = question_q;
        question_valid_d = question_valid_q;
        answer_d         = answer_q;
        timed_out_d      = timed_out_q;
        pass_d           = 1'b0;
        obc_reset_d      = 1'b0;
        override_d       = override_q;
        fail_count_d     = fail_count_q;
        fail_next        = fail_count_q + 4'd1;
        lfsr_adv         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                question_d       = lfsr_val;
                lfsr_adv         = 1'b1;
                timer_d          = 8'd0;
                question_valid_d = 1'b1;
                state_d          = ST_WAIT;
            end
            ST_WAIT: begin
                // An answer landing on the final WAIT cycle wins over the timeout.
                if (obc.answer_valid) begin
                    answer_d         = obc.answer_obc;
                    timed_out_d      = 1'b0;
                    question_valid_d = 1'b0;
                    state_d          = ST_CHECK;
                end else if (timer_q == WAIT_LAST) begin
                    timed_out_d      = 1'b1;
                    question_valid_d = 1'b0;
                    state_d          = ST_CHECK;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            ST_CHECK: begin
                timer_d = 8'd0;
                if (!timed_out_q && answer_q == expected_answer(question_q)) begin
                    pass_d       = 1'b1;
                    fail_count_d = 4'd0;
                    state_d      = ST_PAUSE;
                end else begin
                    fail_count_d = fail_next;
                    obc_reset_d  = timed_out_q;
                    if (fail_next == FAIL_MAX) begin
                        override_d = 1'b1;
                        state_d    = ST_SHUTDOWN;
                    end else begin
                        state_d = ST_PAUSE;
                    end
                end
            end
            ST_PAUSE: begin
                if (timer_q == PAUSE_LAST) begin
                    timer_d = 8'd0;
                    state_d = enable ? ST_ISSUE : ST_IDLE;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            ST_SHUTDOWN: begin
                question_valid_d = 1'b0;
                override_d       = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q          <= ST_IDLE;
            timer_q          <= 8'd0;
            question_q       <= 4'd0;
            question_valid_q <= 1'b0;
            answer_q         <= 4'd0;
            timed_out_q      <= 1'b0;
            pass_q           <= 1'b0;
            obc_reset_q      <= 1'b0;
            override_q       <= 1'b0;
            fail_count_q     <= 4'd0;
        end else begin
            state_q          <= state_d;
            timer_q          <= timer_d;
            question_q       <= question_d;
            question_valid_q <= question_valid_d;
            answer_q         <= answer_d;
            timed_out_q      <= timed_out_d;
            pass_q           <= pass_d;
            obc_reset_q      <= obc_reset_d;
            override_q       <= override_d;
            fail_count_q     <= fail_count_d;
        end
    end

    assign obc.question       = question_q;
    assign obc.question_valid = question_valid_q;
    assign pass               = pass_q;
    assign obc_reset          = obc_reset_q;
    assign override           = override_q;
    assign fail_count         = fail_count_q;

endmodule

// File: doc/obc_challenge_sequencer.md
OBC_CHALLENGE_SEQUENCER -- requirements
Module: obc_challenge_sequencer

Interface
REQ-001 Parameter: TIMEOUT, 16, max WAIT cycles for an OBC answer (legal 1..255).
REQ-002 Parameter: ROUND_INTERVAL, 8, PAUSE cycles between rounds (legal 1..255).
REQ-003 Parameter: FAIL_LIMIT, 3, consecutive failures that trigger SHUTDOWN (legal 1..15).
REQ-004 Port: clk  in  1  single clock; all logic on rising edge.
REQ-005 Port: reset  in  1  synchronous, active-low reset.
REQ-006 Port: enable  in  1  run request; sampled only in IDLE and PAUSE.
REQ-007 Port: question  out  4  challenge word presented to OBC.
REQ-008 Port: question_valid  out  1  question is live and awaiting answer.
REQ-009 Port: answer_obc  in  4  OBC answer word.
REQ-010 Port: answer_valid  in  1  one-cycle strobe qualifying answer_obc.
REQ-011 Port: pass  out  1  one-cycle pulse, correct answer.
REQ-012 Port: obc_reset  out  1  one-cycle pulse requesting OBC reset after a timeout failure.
REQ-013 Port: override  out  1  sticky; switch to backup OBC.
REQ-014 Port: fail_count  out  4  current consecutive-failure count.

Function
REQ-015 States SHALL be IDLE, ISSUE, WAIT, CHECK, PAUSE, SHUTDOWN; all outputs registered.
REQ-016 Question source SHALL be 4-bit LFSR, seed 4'b0001, next = {l[2:0], l[3]^l[2]}, advanced once per ISSUE; never zero.
REQ-017 Expected answer SHALL be a[0]=~q[0], a[1]=q[0]^q[1], a[2]=q[1]^q[2], a[3]=q[2]^q[3].
REQ-018 IDLE: enable=1 -> ISSUE; else stay.
REQ-019 ISSUE (1 cycle): question<=LFSR value, LFSR advances, timer<=0, question_valid<=1 -> WAIT.
REQ-020 WAIT: question_valid=1, question stable; answer_valid=1 captures answer_obc -> CHECK.
REQ-021 WAIT: timer increments each cycle; after TIMEOUT cycles with no answer_valid -> CHECK flagged as timeout.
REQ-022 answer_valid in the same cycle as timeout expiry SHALL count as an answer, not a timeout.
REQ-023 question_valid SHALL deassert on the WAIT->CHECK edge; answer_valid outside WAIT is ignored.
REQ-024 CHECK (1 cycle), match: pass pulse, fail_count<=0 -> PAUSE.
REQ-025 CHECK, mismatch or timeout: fail_count<=fail_count+1; timeout also pulses obc_reset.
REQ-026 CHECK: if incremented fail_count == FAIL_LIMIT -> SHUTDOWN, else PAUSE.
REQ-027 PAUSE: wait ROUND_INTERVAL cycles; then enable=1 -> ISSUE, enable=0 -> IDLE.
REQ-028 SHUTDOWN: override=1, question_valid=0, no further rounds; exit only by reset.
REQ-029 enable deasserted during ISSUE/WAIT/CHECK SHALL NOT abort the round.
REQ-030 fail_count SHALL never exceed FAIL_LIMIT.

Reset
REQ-031 reset=0 at a clk edge: state IDLE, LFSR 4'b0001, question 0, question_valid 0, pass 0, obc_reset 0, override 0, fail_count 0, timers 0.
REQ-032 Reset SHALL take effect from any state mid-round, including SHUTDOWN; any pending answer is discarded.

Structure
REQ-033 Shared package SHALL hold the state encoding, the LFSR seed/next function and the expected-answer function.
REQ-034 One sub-module, obc_question_lfsr (advance input, 4-bit value output), SHALL be instantiated.

Verification
REQ-035 Reset, enable=1: question=4'b0001 with question_valid 2 cycles later; answer 4'b0010 -> pass pulse, fail_count 0.
REQ-036 Second round: question=4'b0010 after ROUND_INTERVAL; answer 4'b0111 -> pass; wrong answer 4'b0000 -> fail_count 1, no obc_reset.
REQ-037 No answer_valid for TIMEOUT=16 cycles -> obc_reset one-cycle pulse, fail_count 1, PAUSE then next question.
REQ-038 Three consecutive failures (FAIL_LIMIT=3) -> override=1 sticky, question_valid=0; pass after one failure resets fail_count to 0.
REQ-039 answer_valid on the exact timeout cycle with correct answer -> pass, no obc_reset; stray answer_valid in PAUSE ignored.
REQ-040 reset=0 during WAIT and during SHUTDOWN -> all outputs at reset values next cycle, first new question 4'b0001.
